// File: rtl/seq_gen_pkg.sv
// Shared types and counter widths for the bit-serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int REP_CNT_W = 4;
  localparam int GAP_CNT_W = 4;

  // Bit counter only has to hold WIDTH-1, so clog2 of the pattern length suffices.
  function automatic int bit_cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Parallel-load, shift-left register; the MSB flop output is the serial bit.
module seq_gen_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Load wins over shift; shifting pulls a zero into the LSB.
  assign q_next[0] = load ? din[0] : (shift ? 1'b0 : q_reg[0]);

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
    assign q_next[gi] = load ? din[gi] : (shift ? q_reg[gi-1] : q_reg[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign msb = q_reg[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Bit-serial pattern generator: shifts a latched pattern out MSB first,
// repeated a programmable number of times with an idle gap in between.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       repeat_num,
  input  logic [3:0]       gap,
  output logic             data,
  output logic             data_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int BIT_CNT_W = bit_cnt_width(WIDTH);

  state_t                 state_reg;
  logic [WIDTH-1:0]       shadow_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic [REP_CNT_W-1:0]   rep_left_reg;
  logic [GAP_CNT_W-1:0]   gap_len_reg;
  logic [GAP_CNT_W-1:0]   gap_cnt_reg;
  logic                   data_valid_reg;
  logic                   frame_start_reg;
  logic                   busy_reg;
  logic                   done_reg;

  logic                   shreg_load;
  logic                   shreg_shift;
  logic [WIDTH-1:0]       shreg_din;
  logic                   last_bit;
  logic                   last_rep;

  assign last_bit = (bit_cnt_reg == '0);
  assign last_rep = (rep_left_reg == REP_CNT_W'(1));

  // The shift register is loaded with zeros whenever no bit is driven, so its
  // MSB can feed the data output directly and still read 0 outside a burst.
  always_comb begin
    shreg_load  = 1'b0;
    shreg_shift = 1'b0;
    shreg_din   = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_load = 1'b1;
          shreg_din  = pattern;
        end
      end
      SHIFT: begin
        if (abort) begin
          shreg_load = 1'b1;
        end else if (!last_bit) begin
          shreg_shift = 1'b1;
        end else if (!last_rep && gap_len_reg == '0) begin
          shreg_load = 1'b1;
          shreg_din  = shadow_reg;
        end else begin
          shreg_load = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          shreg_load = 1'b1;
        end else if (gap_cnt_reg == '0) begin
          shreg_load = 1'b1;
          shreg_din  = shadow_reg;
        end
      end
      default: begin
        shreg_load = 1'b1;
      end
    endcase
  end

  seq_gen_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (shreg_load),
    .shift (shreg_shift),
    .din   (shreg_din),
    .msb   (data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shadow_reg      <= '0;
      bit_cnt_reg     <= '0;
      rep_left_reg    <= '0;
      gap_len_reg     <= '0;
      gap_cnt_reg     <= '0;
      data_valid_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shadow_reg      <= pattern;
            rep_left_reg    <= (repeat_num == '0) ? REP_CNT_W'(1) : repeat_num;
            gap_len_reg     <= gap;
            bit_cnt_reg     <= BIT_CNT_W'(WIDTH - 1);
            state_reg       <= SHIFT;
            data_valid_reg  <= 1'b1;
            frame_start_reg <= 1'b1;
            busy_reg        <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_reg      <= IDLE;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
          end else if (!last_bit) begin
            bit_cnt_reg <= bit_cnt_reg - BIT_CNT_W'(1);
          end else begin
            rep_left_reg <= rep_left_reg - REP_CNT_W'(1);
            if (last_rep) begin
              state_reg      <= IDLE;
              data_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
            end else if (gap_len_reg == '0) begin
              bit_cnt_reg     <= BIT_CNT_W'(WIDTH - 1);
              frame_start_reg <= 1'b1;
            end else begin
              state_reg      <= GAP;
              gap_cnt_reg    <= gap_len_reg - GAP_CNT_W'(1);
              data_valid_reg <= 1'b0;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (gap_cnt_reg == '0) begin
            state_reg       <= SHIFT;
            bit_cnt_reg     <= BIT_CNT_W'(WIDTH - 1);
            data_valid_reg  <= 1'b1;
            frame_start_reg <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_CNT_W'(1);
          end
        end
        default: begin
          state_reg      <= IDLE;
          data_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign data_valid  = data_valid_reg;
  assign frame_start = frame_start_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: doc/seq_gen.md
# seq_gen

Bit-serial pattern generator: the transmit-side counterpart of the serial sequence detector. On a start request it latches a WIDTH-bit pattern and shifts it out MSB first, one bit per clock with a valid qualifier. It can repeat the pattern a programmable number of times with a programmable idle gap between repetitions. It drives the detector's `data` input directly, or feeds a bench or another serial sink.

## Interface
- `WIDTH`, default 8: pattern length in bits (2..32).
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request, sampled only while `busy`=0.
- `abort`  input  1: synchronous cancel of a transfer in progress.
- `pattern`  input  WIDTH: bits to send, latched when `start` is accepted.
- `repeat_num`  input  4: number of transmissions; 0 is treated as 1. Latched with `pattern`.
- `gap`  input  4: idle cycles between repetitions. Latched with `pattern`.
- `data`  output  1: serial bit, MSB first; 0 when not valid.
- `data_valid`  output  1: `data` carries a pattern bit.
- `frame_start`  output  1: high on the first bit of every repetition.
- `busy`  output  1: transfer in progress; `start` is ignored while high.
- `done`  output  1: one-cycle pulse after the last bit of the final repetition.

## Operation
- Reset is asynchronous and active-low, fixed for this block.
  - On reset, all outputs go to 0, the FSM goes to IDLE, and the counters and shadow registers clear.
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: driving pattern bits.
  - GAP: idle cycles between repetitions.
- IDLE:
  - If `start`=1, latch `pattern` into the shift register, `repeat_num` (0 becomes 1) into `rep_left`, and `gap` into `gap_len`.
  - Then go to SHIFT with `bit_cnt`=WIDTH-1.
- SHIFT:
  - `data` is the shift register MSB and `data_valid`=1.
  - Each cycle the register shifts left and `bit_cnt` decrements.
  - When `bit_cnt`=0 (last bit), decrement `rep_left`. Then:
    - if `rep_left` becomes 0, go to IDLE and pulse `done`;
    - else if `gap_len`=0, reload the latched pattern and stay in SHIFT, so repetitions run back to back;
    - else go to GAP with `gap_cnt`=`gap_len`-1.
- GAP:
  - `data`=0 and `data_valid`=0.
  - When `gap_cnt`=0, reload the pattern and go to SHIFT.
- A separate copy of the latched pattern is kept for reloads. The `pattern` input is not re-sampled after acceptance.
- `abort` (any non-IDLE state):
  - Go to IDLE at the next edge; `data_valid`, `busy` and `frame_start` drop.
  - No `done` pulse.
  - `abort` has priority over everything else. It is ignored in IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `start` and `abort` high together in IDLE: `start` is accepted.
- Reset asserted mid-transfer: immediate return to reset values, no `done`.

## Timing
- All outputs are registered.
- Let `start` be sampled high at edge k:
  - first bit is valid in the cycle after edge k, with `frame_start`=1 and `busy`=1;
  - bit i (0 = MSB) is valid in the cycle after edge k+i.
- One repetition occupies WIDTH cycles, followed by `gap_len` idle cycles when further repetitions remain.
- `busy` is high from the cycle after the accepting edge through the last bit of the final repetition, including gap cycles.
- `done` is high for the single cycle after the final bit, with `busy`=0 in that cycle.
  - A new `start` may be sampled in that same `done` cycle, giving a back-to-back transfer with exactly one idle cycle.
- Total cycles from the accepting edge to `done` = N·WIDTH + (N-1)·`gap_len` + 1, where N is the effective repeat count.

## Structure
- Package `seq_gen_pkg` holds:
  - the state typedef (IDLE, SHIFT, GAP);
  - the counter-width constants: clog2 of WIDTH, and 4 for the repeat and gap counters.
- Sub-module `seq_gen_shreg` is the parallel-load, shift-left register with MSB output and load/shift enables.
- The FSM and counters live in the top module.

## Test plan
- Reset, then `pattern`=8'b0111_0001, `repeat_num`=1, `gap`=0, `start` for one cycle:
  - `data` = 0,1,1,1,0,0,0,1 on 8 consecutive valid cycles;
  - `frame_start` only on the first bit;
  - `done` in cycle 9.
- `pattern`=8'hA5, `repeat_num`=3, `gap`=2:
  - bursts of 8 valid bits, 2 invalid cycles between bursts, `frame_start` at the start of each burst;
  - `done` 29 cycles after the accepting edge.
- `repeat_num`=0, `gap`=5: exactly one burst, no gap, `done` after 9 cycles.
- `repeat_num`=2, `gap`=0: 16 contiguous valid bits, `frame_start` at bits 0 and 8.
- `abort` during bit 3 of the first burst:
  - next cycle `data_valid`=0 and `busy`=0;
  - `done` never asserts;
  - a new `start` is then accepted normally.
- Edge cases:
  - `start` pulsed mid-transfer is ignored;
  - `start` in the `done` cycle launches a new frame one cycle later;
  - `rst_n` low mid-burst clears all outputs asynchronously, before the next clock edge.
